lcv_mul_acc_sched: RTL and testbench

- Round-robin scheduler that shares one registered multiply-accumulate stage among NUM_REQ requesters.
- Each requester submits a job: a burst of signed (a,b) operand beats plus a bias. The block accumulates bias + sum(a*b) and returns the result with the requester index.
- Sits between per-lane DSP clients (filters, dot products) and the single DSP-mapped MAC stage; one job is in flight at a time.

---
 rtl/lcv_mul_acc_sched_pkg.sv | 40 ++++
 rtl/lcv_mul_acc_sched_if.sv | 47 ++++
 rtl/lcv_mul_acc_sched_stage.sv | 61 ++++++
 rtl/lcv_mul_acc_sched.sv | 147 ++++++++++++++
 tb/tb_lcv_mul_acc_sched.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcv_mul_acc_sched_pkg.sv
// Shared types, default widths and round-robin helper for the lcv_mul_acc_sched MAC scheduler.
// Optional saturating arithmetic is enabled by defining LCV_MUL_ACC_SCHED_SAT_EN.
package lcv_mul_acc_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned OP_W_DEF    = 16;
    localparam int unsigned ACC_W_DEF   = 33;
    localparam int unsigned CNT_W_DEF   = 8;

    // First set bit of vec[n-1:0], scanning upward from start and wrapping at n (n <= 16).
    function automatic logic [3:0] rr_find_first(
        input logic [15:0] vec,
        input logic [3:0]  start,
        input int unsigned n
    );
        int unsigned sum;
        logic        found;
        rr_find_first = start;
        found         = 1'b0;
        for (int unsigned k = 0; k < 16; k++) begin
            if (k < n) begin
                sum = 32'(start) + k;
                if (sum >= n) begin
                    sum = sum - n;
                end
                if (!found && vec[sum[3:0]]) begin
                    rr_find_first = sum[3:0];
                    found         = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/lcv_mul_acc_sched_if.sv
// Request/response bundle between DSP clients and the lcv_mul_acc_sched MAC scheduler.
// rsp_sat exists only when LCV_MUL_ACC_SCHED_SAT_EN is defined.
interface lcv_mul_acc_sched_if
    import lcv_mul_acc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
);
    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*OP_W-1:0]  req_a;
    logic [NUM_REQ*OP_W-1:0]  req_b;
    logic [NUM_REQ*ACC_W-1:0] req_bias;
    logic [NUM_REQ-1:0]       req_last;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [IDX_W-1:0]         rsp_idx;
    logic [ACC_W-1:0]         rsp_data;
    logic [CNT_W-1:0]         rsp_beats;
    logic                     busy;
`ifdef LCV_MUL_ACC_SCHED_SAT_EN
    logic                     rsp_sat;

    modport master (
        output req_valid, req_a, req_b, req_bias, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_idx, rsp_data, rsp_beats, busy, rsp_sat
    );
    modport slave (
        input  req_valid, req_a, req_b, req_bias, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_idx, rsp_data, rsp_beats, busy, rsp_sat
    );
`else
    modport master (
        output req_valid, req_a, req_b, req_bias, req_last, rsp_ready,
        input  req_ready, rsp_valid, rsp_idx, rsp_data, rsp_beats, busy
    );
    modport slave (
        input  req_valid, req_a, req_b, req_bias, req_last, rsp_ready,
        output req_ready, rsp_valid, rsp_idx, rsp_data, rsp_beats, busy
    );
`endif

endinterface

// File: rtl/lcv_mul_acc_sched_stage.sv
// Registered multiply-accumulate stage: o_acc <= sext(a*b) + c when enabled (DSP inference target).
// With LCV_MUL_ACC_SCHED_SAT_EN the sum clamps and a sticky o_sat flag is kept (cleared by i_clr).
module lcv_mul_acc_stage #(
    parameter int unsigned OP_W  = 16,
    parameter int unsigned ACC_W = 33
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_en,
    input  logic signed [OP_W-1:0]  i_a,
    input  logic signed [OP_W-1:0]  i_b,
    input  logic signed [ACC_W-1:0] i_c,
`ifdef LCV_MUL_ACC_SCHED_SAT_EN
    input  logic                    i_clr,
    output logic                    o_sat,
`endif
    output logic signed [ACC_W-1:0] o_acc
);

    logic signed [2*OP_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_sum;

    assign w_prod = i_a * i_b;

`ifdef LCV_MUL_ACC_SCHED_SAT_EN
    logic signed [ACC_W:0] w_wide;
    logic                  w_ovf;

    // One guard bit: top two bits disagreeing means the ACC_W result overflowed.
    assign w_wide = (ACC_W+1)'(w_prod) + (ACC_W+1)'(i_c);
    assign w_ovf  = w_wide[ACC_W] ^ w_wide[ACC_W-1];

    always_comb begin
        w_sum = w_wide[ACC_W-1:0];
        if (w_ovf) begin
            w_sum = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sat <= 1'b0;
        end else if (i_clr) begin
            o_sat <= 1'b0;
        end else if (i_en && w_ovf) begin
            o_sat <= 1'b1;
        end
    end
`else
    assign w_sum = ACC_W'(w_prod) + i_c;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_acc <= '0;
        end else if (i_en) begin
            o_acc <= w_sum;
        end
    end

endmodule

// File: rtl/lcv_mul_acc_sched.sv
// Round-robin scheduler sharing one registered MAC stage among NUM_REQ requesters, one job in flight.
// Define LCV_MUL_ACC_SCHED_SAT_EN for saturating accumulation and the rsp_sat output.
module lcv_mul_acc_sched
    import lcv_mul_acc_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned ACC_W   = ACC_W_DEF,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    lcv_mul_acc_sched_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   r_grant;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic               r_first;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_any_valid;
    logic [IDX_W-1:0]   w_start;
    logic [IDX_W-1:0]   w_pick;
    logic               w_grant_evt;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_req_ready;
    logic               w_rsp_valid;

    logic signed [OP_W-1:0]  w_a;
    logic signed [OP_W-1:0]  w_b;
    logic signed [ACC_W-1:0] w_c;
    logic signed [ACC_W-1:0] w_acc;

    assign w_any_valid = |bus.req_valid;
    assign w_start     = (r_rr_ptr == IDX_W'(NUM_REQ - 1)) ? '0 : r_rr_ptr + 1'b1;
    assign w_pick      = IDX_W'(rr_find_first(16'(bus.req_valid), 4'(w_start), NUM_REQ));
    assign w_grant_evt = (r_state == ST_IDLE) && w_any_valid;
    assign w_xfer      = (r_state == ST_RUN) && bus.req_valid[r_grant];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = '0;
        w_rsp_valid = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_req_ready[r_grant] = 1'b1;
                if (w_xfer && bus.req_last[r_grant]) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // rr_ptr starts at NUM_REQ-1 so the first search begins at requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant  <= '0;
            r_rr_ptr <= IDX_W'(NUM_REQ - 1);
            r_first  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (w_grant_evt) begin
                r_grant  <= w_pick;
                r_rr_ptr <= w_pick;
                r_first  <= 1'b1;
            end
            if (w_xfer) begin
                r_first <= 1'b0;
                if (r_first) begin
                    r_cnt <= CNT_W'(1);
                end else if (!(&r_cnt)) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign w_a = $signed(bus.req_a[r_grant*OP_W +: OP_W]);
    assign w_b = $signed(bus.req_b[r_grant*OP_W +: OP_W]);
    assign w_c = r_first ? $signed(bus.req_bias[r_grant*ACC_W +: ACC_W]) : w_acc;

`ifdef LCV_MUL_ACC_SCHED_SAT_EN
    logic w_sat;

    lcv_mul_acc_stage #(
        .OP_W  (OP_W),
        .ACC_W (ACC_W)
    ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_xfer),
        .i_a   (w_a),
        .i_b   (w_b),
        .i_c   (w_c),
        .i_clr (w_grant_evt),
        .o_sat (w_sat),
        .o_acc (w_acc)
    );

    assign bus.rsp_sat = w_sat;
`else
    lcv_mul_acc_stage #(
        .OP_W  (OP_W),
        .ACC_W (ACC_W)
    ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_xfer),
        .i_a   (w_a),
        .i_b   (w_b),
        .i_c   (w_c),
        .o_acc (w_acc)
    );
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_idx   = r_grant;
    assign bus.rsp_data  = w_acc;
    assign bus.rsp_beats = r_cnt;
    assign bus.busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_lcv_mul_acc_sched.sv
// Directed, table-driven bench for lcv_mul_acc_sched (NUM_REQ=4, OP_W=16, ACC_W=33, CNT_W=8).
// Expectations follow LCV_MUL_ACC_SCHED_SAT_EN when it is defined.
module tb_lcv_mul_acc_sched;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    lcv_mul_acc_sched_if #(.NUM_REQ(4), .OP_W(16), .ACC_W(33), .CNT_W(8)) bus ();

    lcv_mul_acc_sched #(.NUM_REQ(4), .OP_W(16), .ACC_W(33), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          req;
        logic [32:0] bias;
        int          n;
        int          a0, b0, a1, b1, a2, b2;
        logic [32:0] exp_data;
        bit          exp_sat;
    } vec_t;

    vec_t tbl[8];
    int   ja[300];
    int   jb[300];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.req_last  = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Sends beats 0..n_send-1 of an n-beat job; bubbles of junk data every bub_every beats.
    task automatic run_job(input int idx, input logic [32:0] bias, input int n,
                           input int n_send, input int bub_every);
        int w;
        bus.req_bias[idx*33 +: 33] = bias;
        for (int k = 0; k < n_send; k++) begin
            if (bub_every > 0 && k > 0 && (k % bub_every) == 0) begin
                bus.req_valid[idx]       = 1'b0;
                bus.req_a[idx*16 +: 16]  = 16'd1000;
                bus.req_b[idx*16 +: 16]  = 16'd1000;
                bus.req_last[idx]        = 1'b1;
                @(posedge clk);
                #1;
            end
            bus.req_valid[idx]      = 1'b1;
            bus.req_a[idx*16 +: 16] = 16'(ja[k]);
            bus.req_b[idx*16 +: 16] = 16'(jb[k]);
            bus.req_last[idx]       = (k == n - 1);
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!bus.req_ready[idx] && w < 50);
            if (!bus.req_ready[idx]) begin
                chk("beat_ready_timeout", 64'(bus.req_ready), 64'(1 << idx));
                bus.req_valid[idx] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (k == 0) bus.req_bias[idx*33 +: 33] = 33'h0_5A5A_5A5A;
        end
        bus.req_valid[idx] = 1'b0;
        bus.req_last[idx]  = 1'b0;
    endtask

    task automatic expect_rsp(input int idx, input logic [32:0] data, input int beats,
                              input bit imm, input bit sat);
        int w = 0;
        @(negedge clk);
        if (imm) chk("rsp_latency", 64'(bus.rsp_valid), 64'd1);
        while (!bus.rsp_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rsp_idx", 64'(bus.rsp_idx), 64'(idx));
        chk("rsp_data", 64'(bus.rsp_data), 64'(data));
        chk("rsp_beats", 64'(bus.rsp_beats), 64'(beats));
`ifdef LCV_MUL_ACC_SCHED_SAT_EN
        chk("rsp_sat", 64'(bus.rsp_sat), 64'(sat));
`endif
        if (bus.rsp_ready) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("rsp_one_cycle", 64'(bus.rsp_valid), 64'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        //           req bias               n  a0      b0      a1     b1      a2  b2  exp                         sat
        tbl[0] = '{1, 33'd10,              3, 3,      4,      -2,    5,      7,  7,  33'd61,                      1'b0};
        tbl[1] = '{2, 33'(-100),           2, -300,   200,    0,     5,      0,  0,  33'(-60100),                 1'b0};
        tbl[2] = '{3, 33'd0,               1, -32768, -32768, 0,     0,      0,  0,  33'd1073741824,              1'b0};
`ifdef LCV_MUL_ACC_SCHED_SAT_EN
        tbl[3] = '{0, 33'h0_FFFF_FFFF,     1, 1,      1,      0,     0,      0,  0,  33'h0_FFFF_FFFF,             1'b1};
        tbl[6] = '{3, 33'h1_0000_0000,     1, -1,     1,      0,     0,      0,  0,  33'h1_0000_0000,             1'b1};
        tbl[7] = '{1, 33'h0_FFFF_FFFF,     2, 1,      1,      -1,    1,      0,  0,  33'h0_FFFF_FFFE,             1'b1};
`else
        tbl[3] = '{0, 33'h0_FFFF_FFFF,     1, 1,      1,      0,     0,      0,  0,  33'h1_0000_0000,             1'b0};
        tbl[6] = '{3, 33'h1_0000_0000,     1, -1,     1,      0,     0,      0,  0,  33'h0_FFFF_FFFF,             1'b0};
        tbl[7] = '{1, 33'h0_FFFF_FFFF,     2, 1,      1,      -1,    1,      0,  0,  33'h0_FFFF_FFFF,             1'b0};
`endif
        tbl[4] = '{2, 33'd5,               3, 32767,  -32768, 32767, 32767,  -1, -1, 33'(-32761),                 1'b0};
        tbl[5] = '{0, 33'(-1),             1, 2,      -3,     0,     0,      0,  0,  33'(-7),                     1'b0};

        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_bias  = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("rst_rsp_idx", 64'(bus.rsp_idx), 64'd0);
        chk("rst_rsp_beats", 64'(bus.rsp_beats), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
`ifdef LCV_MUL_ACC_SCHED_SAT_EN
        chk("rst_rsp_sat", 64'(bus.rsp_sat), 64'd0);
`endif
        #1 rst_n = 1'b1;

        // Reset mid-RUN: two of three beats sent, then reset drops the job
        ja[0] = 1; jb[0] = 1; ja[1] = 2; jb[1] = 1; ja[2] = 3; jb[2] = 1;
        run_job(0, 33'd5, 3, 2, 0);
        chk("midrun_busy", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 64'(bus.busy), 64'd0);
        chk("midrun_rst_ready", 64'(bus.req_ready), 64'd0);
        chk("midrun_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("midrun_rst_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("midrun_rst_rsp_beats", 64'(bus.rsp_beats), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dropped_no_rsp", 64'(bus.rsp_valid), 64'd0);
        end
        bus.req_bias[0 +: 33]  = 33'd0;
        bus.req_a[0 +: 16]     = 16'd2;
        bus.req_b[0 +: 16]     = 16'd3;
        bus.req_a[16 +: 16]    = 16'd9;
        bus.req_b[16 +: 16]    = 16'd9;
        bus.req_last           = 4'b0011;
        bus.req_valid          = 4'b0011;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (bus.req_ready == 4'b0000 && w < 20);
        chk("post_reset_grant", 64'(bus.req_ready), 64'b0001);
        @(posedge clk);
        #1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        expect_rsp(0, 33'd6, 1, 1, 1'b0);

        // Round-robin with all requesters valid
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i*16 +: 16]    = 16'(i);
            bus.req_b[i*16 +: 16]    = 16'd1;
            bus.req_bias[i*33 +: 33] = 33'd0;
        end
        bus.req_last  = 4'b1111;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!bus.rsp_valid && w < 50);
            chk("rr_valid", 64'(bus.rsp_valid), 64'd1);
            chk("rr_idx", 64'(bus.rsp_idx), 64'(k % 4));
            chk("rr_data", 64'(bus.rsp_data), 64'(k % 4));
            @(posedge clk);
            #1;
            if (k == 4) begin
                bus.req_valid = '0;
                bus.req_last  = '0;
            end
        end

        // Table of single jobs
        for (int i = 0; i < 8; i++) begin
            ja[0] = tbl[i].a0; jb[0] = tbl[i].b0;
            ja[1] = tbl[i].a1; jb[1] = tbl[i].b1;
            ja[2] = tbl[i].a2; jb[2] = tbl[i].b2;
            run_job(tbl[i].req, tbl[i].bias, tbl[i].n, tbl[i].n, 0);
            expect_rsp(tbl[i].req, tbl[i].exp_data, tbl[i].n, 1, tbl[i].exp_sat);
        end

        // Backpressure: RESP held 5 cycles while another requester waits
        bus.rsp_ready = 1'b0;
        bus.req_a[48 +: 16]   = 16'(-6);
        bus.req_b[48 +: 16]   = 16'd9;
        bus.req_bias[99 +: 33] = 33'd0;
        ja[0] = 4; jb[0] = 5;
        run_job(2, 33'd7, 1, 1, 0);
        expect_rsp(2, 33'd27, 1, 1, 1'b0);
        bus.req_last[3]  = 1'b1;
        bus.req_valid[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_rsp_data", 64'(bus.rsp_data), 64'd27);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_busy", 64'(bus.busy), 64'd1);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_single_handshake", 64'(bus.rsp_valid), 64'd0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.req_ready[3] && w < 20);
        chk("bp_next_grant", 64'(bus.req_ready), 64'b1000);
        @(posedge clk);
        #1;
        bus.req_valid[3] = 1'b0;
        bus.req_last[3]  = 1'b0;
        expect_rsp(3, 33'(-54), 1, 1, 1'b0);

        // 300-beat job with bubbles: acc untouched by bubbles, beat count saturates
        for (int k = 0; k < 300; k++) begin
            ja[k] = 1;
            jb[k] = 1;
        end
        run_job(1, 33'd0, 300, 300, 7);
        expect_rsp(1, 33'd300, 255, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
